// File: rtl/mux_scan_sequencer_if.sv
// Bundle between the scan sequencer and the mux it drives.
// The master side supplies the controls and the mux output.
// The slave side (the sequencer) returns the select, the samples and the pulses.
interface mux_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               y;
    logic [1:0]         s;
    logic [3:0]         samples;
    logic               strobe;
    logic               valid;

    modport master (
        output en, mask, dwell, y,
        input  s, samples, strobe, valid
    );

    modport slave (
        input  en, mask, dwell, y,
        output s, samples, strobe, valid
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for a 4:1 mux.
// It holds each enabled channel for DWELL+1 cycles and then captures the mux output into that channel's sample bit.
// STROBE flags every capture. VALID flags the capture that closes a sweep.
module mux_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux_scan_sequencer_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         s_q, s_d;
    logic [3:0]         samples_q, samples_d;
    logic               strobe_q, strobe_d;
    logic               valid_q, valid_d;

    logic               run;
    logic [3:0]         above;
    logic [1:0]         next_ch;
    logic               wraps;

    // Lowest set bit index of a 4-bit vector (0 when empty).
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign run = bus.en && (bus.mask != 4'b0000);

    // Channels that are enabled and sit strictly above the current select.
    for (genvar gi = 0; gi < 4; gi++) begin : g_above
        assign above[gi] = bus.mask[gi] && (s_q < 2'(gi));
    end

    // Advance within the sweep if possible; otherwise wrap to the lowest enabled channel.
    // A wrap is what marks the end of a sweep.
    assign wraps   = (above == 4'b0000);
    assign next_ch = wraps ? lowest_set(bus.mask) : lowest_set(above);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: scanning continues only while enabled with a non-empty mask.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run)  state_d = ST_DWELL;
            ST_DWELL: if (!run) state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    // The >= compare means a lowered DWELL fires at once, so the counter never wraps.
    always_comb begin
        cnt_d     = cnt_q;
        s_d       = s_q;
        samples_d = samples_q;
        strobe_d  = 1'b0;
        valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (run) s_d = lowest_set(bus.mask);
            end
            ST_DWELL: begin
                if (!run) begin
                    cnt_d = '0;
                end else if (cnt_q >= bus.dwell) begin
                    samples_d[s_q] = bus.y;
                    strobe_d       = 1'b1;
                    valid_d        = wraps;
                    s_d            = next_ch;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            s_q       <= 2'b00;
            samples_q <= 4'b0000;
            strobe_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            samples_q <= samples_d;
            strobe_q  <= strobe_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.s       = s_q;
    assign bus.samples = samples_q;
    assign bus.strobe  = strobe_q;
    assign bus.valid   = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer, with a behavioural 4:1 mux on Y.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data_q = 4'b1010;   // bit i = D(i+1)
    int         n_total = 0;
    int         n_bad = 0;
    logic [3:0] exp_samples = 4'b0000;
    logic [1:0] exp_cur_s = 2'b00;

    mux_scan_sequencer_if #(.DWELL_W(8)) bus ();

    mux_scan_sequencer #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.y = data_q[bus.s];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        bus.en = 1'b0; bus.mask = 4'b0000; bus.dwell = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.en = 1'b1; bus.mask = 4'b1111; bus.dwell = 8'd0; data_q = 4'b1010;
        repeat (6) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        n_total++;
        if (bus.s !== 2'b00 || bus.samples !== 4'b0000 || bus.strobe !== 1'b0 || bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: s=%b samples=%b strobe=%b valid=%b required 00 0000 0 0",
                     bus.s, bus.samples, bus.strobe, bus.valid);
        end
        @(posedge clk); #1;
        n_total++;
        if (bus.s !== 2'b00 || bus.samples !== 4'b0000 || bus.strobe !== 1'b0 || bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: s=%b samples=%b strobe=%b valid=%b required 00 0000 0 0",
                     bus.s, bus.samples, bus.strobe, bus.valid);
        end
        bus.en = 1'b0;
        rst = 1'b0;
        exp_samples = 4'b0000;
        exp_cur_s = 2'b00;
        $display("reset: checked");
    endtask

    // Segments of constant inputs, each started from IDLE; expectations from the schedule arithmetic.
    task automatic test_sweep();
        logic [3:0] m;
        int         d, len, n, p, c;
        int         chs[4];
        logic [1:0] exp_s;
        logic       exp_strobe, exp_valid;
        for (int seg = 0; seg < 12; seg++) begin
            case (seg)
                0: begin m = 4'b1111; d = 3; len = 40; end
                1: begin m = 4'b0101; d = 0; len = 10; end
                2: begin m = 4'b1000; d = 2; len = 12; end
                default: begin m = 4'($urandom_range(1, 15)); d = $urandom_range(0, 6); len = $urandom_range(1, 40); end
            endcase
            bus.en = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
                n_total++;
                if (bus.s !== exp_cur_s || bus.strobe !== 1'b0 || bus.valid !== 1'b0 || bus.samples !== exp_samples) begin
                    n_bad++;
                    $display("FAIL sweep_idle seg=%0d: s=%b strobe=%b valid=%b samples=%b required %b 0 0 %b",
                             seg, bus.s, bus.strobe, bus.valid, bus.samples, exp_cur_s, exp_samples);
                end
            end
            if (seg < 3) data_q = 4'b1010;
            else         data_q = 4'($urandom);
            n = 0;
            for (int i = 0; i < 4; i++) if (m[i]) begin chs[n] = i; n++; end
            bus.mask = m; bus.dwell = 8'(d); bus.en = 1'b1;
            for (int j = 0; j <= len; j++) begin
                @(posedge clk); #1;
                p = j / (d + 1);
                exp_s = 2'(chs[p % n]);
                exp_strobe = (j > 0) && (j % (d + 1) == 0);
                exp_valid = exp_strobe && (p % n == 0);
                if (exp_strobe) begin
                    c = chs[(p - 1) % n];
                    exp_samples[c] = data_q[c];
                end
                n_total++;
                if (bus.s !== exp_s || bus.strobe !== exp_strobe || bus.valid !== exp_valid || bus.samples !== exp_samples) begin
                    n_bad++;
                    $display("FAIL sweep seg=%0d j=%0d: s=%b strobe=%b valid=%b samples=%b required %b %b %b %b",
                             seg, j, bus.s, bus.strobe, bus.valid, bus.samples, exp_s, exp_strobe, exp_valid, exp_samples);
                end
                exp_cur_s = exp_s;
            end
            $display("sweep seg=%0d mask=%b dwell=%0d len=%0d samples=%b", seg, m, d, len, exp_samples);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_en_drop();
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.mask = 4'b1111; bus.dwell = 8'd5; bus.en = 1'b1;
        for (int j = 0; j <= 13; j++) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.s !== 2'(j / 6) || bus.strobe !== ((j > 0) && (j % 6 == 0))) begin
                n_bad++;
                $display("FAIL en_drop_run j=%0d: s=%b strobe=%b required %0d %0d",
                         j, bus.s, bus.strobe, j / 6, (j > 0) && (j % 6 == 0));
            end
        end
        bus.en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.s !== 2'b10 || bus.strobe !== 1'b0 || bus.valid !== 1'b0) begin
                n_bad++;
                $display("FAIL en_drop_idle: s=%b strobe=%b valid=%b required 10 0 0", bus.s, bus.strobe, bus.valid);
            end
        end
        bus.en = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.s !== ((j == 6) ? 2'b01 : 2'b00) || bus.strobe !== (j == 6)) begin
                n_bad++;
                $display("FAIL en_restart j=%0d: s=%b strobe=%b required %b %0d",
                         j, bus.s, bus.strobe, (j == 6) ? 2'b01 : 2'b00, j == 6);
            end
        end
        $display("en_drop: checked");
    endtask

    task automatic test_dwell_lower();
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.mask = 4'b1111; bus.dwell = 8'd10; bus.en = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.s !== 2'b00 || bus.strobe !== 1'b0) begin
                n_bad++;
                $display("FAIL dwell_lower_pre j=%0d: s=%b strobe=%b required 00 0", j, bus.s, bus.strobe);
            end
        end
        bus.dwell = 8'd2;
        for (int j = 7; j <= 16; j++) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.s !== 2'(((j - 7) / 3 + 1) % 4) || bus.strobe !== ((j - 7) % 3 == 0) || bus.valid !== (j == 16)) begin
                n_bad++;
                $display("FAIL dwell_lower j=%0d: s=%b strobe=%b valid=%b required %0d %0d %0d",
                         j, bus.s, bus.strobe, bus.valid, ((j - 7) / 3 + 1) % 4, (j - 7) % 3 == 0, j == 16);
            end
        end
        $display("dwell_lower: checked");
    endtask

    task automatic test_mask_mid();
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.mask = 4'b1111; bus.dwell = 8'd3; data_q = 4'b0101; bus.en = 1'b1;
        @(posedge clk); #1;
        bus.mask = 4'b1110;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.s !== ((j == 4) ? 2'b01 : 2'b00) || bus.strobe !== (j == 4) || bus.valid !== 1'b0 ||
                (j == 4 && bus.samples[0] !== 1'b1)) begin
                n_bad++;
                $display("FAIL mask_mid j=%0d: s=%b strobe=%b valid=%b samples0=%b required %b %0d 0 1",
                         j, bus.s, bus.strobe, bus.valid, bus.samples[0], (j == 4) ? 2'b01 : 2'b00, j == 4);
            end
        end
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.mask = 4'b1100; bus.en = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (bus.s !== 2'b10 || bus.strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_lowest: s=%b strobe=%b required 10 0", bus.s, bus.strobe);
        end
        bus.en = 1'b0;
        $display("mask_mid: checked");
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_en_drop();
        test_dwell_lower();
        test_mask_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
